// File: rtl/dmem_rmw_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM states, RISC-V
// load/store funct3 codes, access-size codes and width helpers.
package dmem_rmw_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Number of byte-offset bits inside one RAM word.
  function automatic int off_width(input int xlen);
    return (xlen == 64) ? 3 : 2;
  endfunction

  // Access size that covers a whole RAM word and needs no read-modify-write.
  function automatic logic [1:0] full_size(input int xlen);
    return (xlen == 64) ? SZ_D : SZ_W;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane handling: extracts and extends load data from a RAM word,
// and merges sub-word store data into a RAM word.
module dmem_lane_fmt
  import dmem_rmw_resp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = 2
) (
  input  logic [2:0]      funct3,
  input  logic [OFFW-1:0] off,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [1:0]      size;
  logic [OFFW-1:0] aoff;
  logic [OFFW+2:0] shamt;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] lane;
  logic            sign;

  // The offset is forced to lane alignment so the shift always lands on a lane
  // boundary; misaligned requests never reach here.
  always_comb begin
    size = funct3[1:0];
    aoff = off;
    mask = '1;
    case (size)
      SZ_B: mask = XLEN'(8'hFF);
      SZ_H: begin
        aoff = off & ~OFFW'(1);
        mask = XLEN'(16'hFFFF);
      end
      SZ_W: begin
        aoff = off & ~OFFW'(3);
        mask = XLEN'(32'hFFFF_FFFF);
      end
      default: aoff = '0;
    endcase
    shamt = {aoff, 3'b000};
    lane  = (rdata >> shamt) & mask;
    case (size)
      SZ_B:    sign = lane[7];
      SZ_H:    sign = lane[15];
      SZ_W:    sign = lane[31];
      default: sign = 1'b0;
    endcase
    load_data = (!funct3[2] && sign) ? (lane | ~mask) : lane;
    merged    = (rdata & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/dmem_rmw_resp.sv
// LSU-side responder for a single-port data RAM without byte enables:
// one request at a time, sub-word stores via read-modify-write.
module dmem_rmw_resp
  import dmem_rmw_resp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 16,
  localparam int OFFW = off_width(XLEN),
  localparam int WAW  = AW - OFFW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [WAW-1:0]  mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t          state, state_n;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [OFFW-1:0] off_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      req_size;
  logic            illegal, misal, req_bad, full_store;
  logic [XLEN-1:0] load_data, merged;

  // Request classification is done on the raw request so errors skip the RAM.
  always_comb begin
    req_size = req_funct3[1:0];
    illegal  = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    if (XLEN == 32 && (req_size == SZ_D || (!req_we && req_funct3 == F3_LWU)))
      illegal = 1'b1;
    case (req_size)
      SZ_H:    misal = req_addr[0];
      SZ_W:    misal = |req_addr[1:0];
      SZ_D:    misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
    req_bad    = illegal | misal;
    full_store = req_we && (req_size == full_size(XLEN));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)         state_n = S_RESP;
          else if (full_store) state_n = S_WR;
          else                 state_n = S_RD;
        end
      end
      S_RD: begin
        mem_en  = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: state_n = we_q ? S_WR : S_RESP;
      S_WR: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        state_n = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request capture, RAM write word and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            off_q     <= req_addr[OFFW-1:0];
            wdata_q   <= req_wdata;
            mem_addr  <= req_addr[AW-1:OFFW];
            rsp_rdata <= '0;
            rsp_err   <= req_bad;
            if (full_store) mem_wdata <= req_wdata;
          end
        end
        S_WAIT: begin
          if (we_q) mem_wdata <= merged;
          else      rsp_rdata <= load_data;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  dmem_lane_fmt #(
    .XLEN (XLEN),
    .OFFW (OFFW)
  ) u_lane_fmt (
    .funct3    (f3_q),
    .off       (off_q),
    .rdata     (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

endmodule

// File: tb/tb_dmem_rmw_resp.sv
// Directed bench for dmem_rmw_resp: a 32-bit and a 64-bit instance, each with
// a behavioural synchronous RAM, checked against hand-computed values.
module tb_dmem_rmw_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        req_valid32, req_ready32, req_we32;
  logic [2:0]  req_funct3_32;
  logic [15:0] req_addr32;
  logic [31:0] req_wdata32;
  logic        rsp_valid32, rsp_ready32, rsp_err32;
  logic [31:0] rsp_rdata32;
  logic        mem_en32, mem_we32;
  logic [13:0] mem_addr32;
  logic [31:0] mem_wdata32, mem_rdata32;

  logic        req_valid64, req_ready64, req_we64;
  logic [2:0]  req_funct3_64;
  logic [15:0] req_addr64;
  logic [63:0] req_wdata64;
  logic        rsp_valid64, rsp_ready64, rsp_err64;
  logic [63:0] rsp_rdata64;
  logic        mem_en64, mem_we64;
  logic [12:0] mem_addr64;
  logic [63:0] mem_wdata64, mem_rdata64;

  logic [31:0] ram32 [0:15];
  logic [63:0] ram64 [0:15];
  logic        pre_en32 = 1'b0, pre_en64 = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [63:0] pre_data = '0;
  int          en_cnt32 = 0, wr_cnt32 = 0, en_cnt64 = 0;

  dmem_rmw_resp #(.XLEN(32), .AW(16)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_we(req_we32),
    .req_funct3(req_funct3_32), .req_addr(req_addr32), .req_wdata(req_wdata32),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready32), .rsp_rdata(rsp_rdata32),
    .rsp_err(rsp_err32), .mem_en(mem_en32), .mem_we(mem_we32),
    .mem_addr(mem_addr32), .mem_wdata(mem_wdata32), .mem_rdata(mem_rdata32)
  );

  dmem_rmw_resp #(.XLEN(64), .AW(16)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
    .req_funct3(req_funct3_64), .req_addr(req_addr64), .req_wdata(req_wdata64),
    .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready64), .rsp_rdata(rsp_rdata64),
    .rsp_err(rsp_err64), .mem_en(mem_en64), .mem_we(mem_we64),
    .mem_addr(mem_addr64), .mem_wdata(mem_wdata64), .mem_rdata(mem_rdata64)
  );

  // Synchronous RAMs with a bench-side preload port.
  always @(posedge clk) begin
    if (pre_en32) ram32[pre_addr] <= pre_data[31:0];
    else if (mem_en32) begin
      en_cnt32 <= en_cnt32 + 1;
      if (mem_we32) begin
        ram32[mem_addr32[3:0]] <= mem_wdata32;
        wr_cnt32 <= wr_cnt32 + 1;
      end else mem_rdata32 <= ram32[mem_addr32[3:0]];
    end
  end

  always @(posedge clk) begin
    if (pre_en64) ram64[pre_addr] <= pre_data;
    else if (mem_en64) begin
      en_cnt64 <= en_cnt64 + 1;
      if (mem_we64) ram64[mem_addr64[3:0]] <= mem_wdata64;
      else          mem_rdata64 <= ram64[mem_addr64[3:0]];
    end
  end

  task automatic preload(input bit wide, input logic [3:0] addr, input logic [63:0] data);
    @(negedge clk);
    pre_addr = addr;
    pre_data = data;
    if (wide) pre_en64 = 1'b1;
    else      pre_en32 = 1'b1;
    @(posedge clk);
    #1;
    pre_en32 = 1'b0;
    pre_en64 = 1'b0;
  endtask

  // Handshake one request, then report cycles to rsp_valid and the cycles at
  // which the RAM read / write strobes were first seen (-1 if never).
  task automatic issue(input bit wide, input logic we, input logic [2:0] f3,
                       input logic [15:0] addr, input logic [63:0] wdata,
                       output int lat, output int rd_cyc, output int wr_cyc,
                       output logic [63:0] rdata, output logic err);
    logic rdy, v, en, mw;
    lat = -1; rd_cyc = -1; wr_cyc = -1; rdata = '0; err = 1'b0;
    @(negedge clk);
    rdy = wide ? req_ready64 : req_ready32;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_ready_at_issue: got %b, want 1", rdy);
    end
    if (wide) begin
      req_valid64 = 1'b1; req_we64 = we; req_funct3_64 = f3;
      req_addr64 = addr; req_wdata64 = wdata;
    end else begin
      req_valid32 = 1'b1; req_we32 = we; req_funct3_32 = f3;
      req_addr32 = addr; req_wdata32 = wdata[31:0];
    end
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    req_valid64 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      en = wide ? mem_en64 : mem_en32;
      mw = wide ? mem_we64 : mem_we32;
      v  = wide ? rsp_valid64 : rsp_valid32;
      if (en && mw && wr_cyc < 0) wr_cyc = c;
      if (en && !mw && rd_cyc < 0) rd_cyc = c;
      if (v === 1'b1) begin
        lat   = c;
        rdata = wide ? rsp_rdata64 : {32'h0, rsp_rdata32};
        err   = wide ? rsp_err64 : rsp_err32;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("[TB] FAIL rsp_timeout: got no rsp_valid, want one within 20 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready32, rsp_valid32, rsp_err32, mem_en32, mem_we32} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl32: got %b, want 10000",
               {req_ready32, rsp_valid32, rsp_err32, mem_en32, mem_we32});
    end
    checks++;
    if ({rsp_rdata32, mem_addr32, mem_wdata32} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data32: got rdata=%h addr=%h wdata=%h, want 0",
               rsp_rdata32, mem_addr32, mem_wdata32);
    end
    checks++;
    if ({req_ready64, rsp_valid64, rsp_err64, mem_en64, mem_we64} !== 5'b10000 ||
        {rsp_rdata64, mem_addr64, mem_wdata64} !== '0) begin
      errors++;
      $display("[TB] FAIL reset64: got ctrl=%b rdata=%h addr=%h wdata=%h, want 10000 and 0",
               {req_ready64, rsp_valid64, rsp_err64, mem_en64, mem_we64},
               rsp_rdata64, mem_addr64, mem_wdata64);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_extract;
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
    logic [15:0] adrs [4] = '{16'd1, 16'd3, 16'd2, 16'd2};
    logic [31:0] exps [4] = '{32'hFFFF_FFAA, 32'h0000_0088, 32'h0000_8899, 32'hFFFF_8899};
    int lat, rdc, wrc;
    logic [63:0] d;
    logic e;
    preload(1'b0, 4'd0, 64'h8899_AABB);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, f3s[i], adrs[i], 64'h0, lat, rdc, wrc, d, e);
      checks++;
      if (d !== {32'h0, exps[i]} || e !== 1'b0 || lat != 3 || rdc != 1 || wrc != -1) begin
        errors++;
        $display("[TB] FAIL load_%0d: got data=%h err=%b lat=%0d rd=%0d wr=%0d, want data=%h err=0 lat=3 rd=1 wr=-1",
                 i, d, e, lat, rdc, wrc, exps[i]);
      end
    end
  endtask

  task automatic test_subword_store;
    int lat, rdc, wrc;
    logic [63:0] d;
    logic e;
    preload(1'b0, 4'd0, 64'h1122_3344);
    issue(1'b0, 1'b1, 3'b000, 16'd2, 64'hEE, lat, rdc, wrc, d, e);
    checks++;
    if (lat != 4 || rdc != 1 || wrc != 3 || d !== 64'h0 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_timing: got lat=%0d rd=%0d wr=%0d data=%h err=%b, want 4 1 3 0 0",
               lat, rdc, wrc, d, e);
    end
    checks++;
    if (ram32[0] !== 32'h11EE_3344) begin
      errors++;
      $display("[TB] FAIL sb_merge: got %h, want 11ee3344", ram32[0]);
    end
    issue(1'b0, 1'b1, 3'b001, 16'd2, 64'hFFFF_5566, lat, rdc, wrc, d, e);
    checks++;
    if (ram32[0] !== 32'h5566_3344 || lat != 4) begin
      errors++;
      $display("[TB] FAIL sh_merge: got %h lat=%0d, want 55663344 lat=4", ram32[0], lat);
    end
  endtask

  task automatic test_full_store;
    int lat, rdc, wrc, en0;
    logic [63:0] d;
    logic e;
    en0 = en_cnt32;
    issue(1'b0, 1'b1, 3'b010, 16'd4, 64'hDEAD_BEEF, lat, rdc, wrc, d, e);
    checks++;
    if (lat != 2 || rdc != -1 || wrc != 1 || d !== 64'h0 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sw_timing: got lat=%0d rd=%0d wr=%0d data=%h err=%b, want 2 -1 1 0 0",
               lat, rdc, wrc, d, e);
    end
    checks++;
    if (ram32[1] !== 32'hDEAD_BEEF || en_cnt32 - en0 != 1) begin
      errors++;
      $display("[TB] FAIL sw_write: got word1=%h accesses=%0d, want deadbeef 1",
               ram32[1], en_cnt32 - en0);
    end
    issue(1'b0, 1'b0, 3'b010, 16'd4, 64'h0, lat, rdc, wrc, d, e);
    checks++;
    if (d !== 64'hDEAD_BEEF || lat != 3) begin
      errors++;
      $display("[TB] FAIL lw_readback: got %h lat=%0d, want deadbeef lat=3", d, lat);
    end
  endtask

  task automatic test_errors;
    logic        wes  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s  [7] = '{3'b001, 3'b010, 3'b111, 3'b100, 3'b011, 3'b110, 3'b011};
    logic [15:0] adrs [7] = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    int lat, rdc, wrc, en0;
    logic [63:0] d;
    logic e;
    for (int i = 0; i < 7; i++) begin
      en0 = en_cnt32;
      issue(1'b0, wes[i], f3s[i], adrs[i], 64'h1234, lat, rdc, wrc, d, e);
      checks++;
      if (e !== 1'b1 || lat != 1 || d !== 64'h0 || en_cnt32 != en0) begin
        errors++;
        $display("[TB] FAIL error_%0d: got err=%b lat=%0d data=%h accesses=%0d, want err=1 lat=1 data=0 accesses=0",
                 i, e, lat, d, en_cnt32 - en0);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_err32 !== 1'b0 || rsp_valid32 !== 1'b0 || req_ready32 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL error_clear: got err=%b valid=%b ready=%b, want 0 0 1",
               rsp_err32, rsp_valid32, req_ready32);
    end
  endtask

  task automatic test_backpressure;
    int lat, rdc, wrc;
    logic [63:0] d;
    logic e;
    rsp_ready32 = 1'b0;
    issue(1'b0, 1'b0, 3'b010, 16'd4, 64'h0, lat, rdc, wrc, d, e);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid32 !== 1'b1 || rsp_rdata32 !== 32'hDEAD_BEEF || req_ready32 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_%0d: got valid=%b data=%h ready=%b, want 1 deadbeef 0",
                 c, rsp_valid32, rsp_rdata32, req_ready32);
      end
    end
    rsp_ready32 = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid32 !== 1'b0 || req_ready32 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release: got valid=%b ready=%b, want 0 1", rsp_valid32, req_ready32);
    end
    issue(1'b0, 1'b0, 3'b100, 16'd5, 64'h0, lat, rdc, wrc, d, e);
    checks++;
    if (d !== 64'hBE || lat != 3) begin
      errors++;
      $display("[TB] FAIL back_to_back: got %h lat=%0d, want be lat=3", d, lat);
    end
  endtask

  task automatic test_reset_midop;
    int lat, rdc, wrc, w0;
    logic [63:0] d;
    logic e;
    preload(1'b0, 4'd0, 64'h1122_3344);
    w0 = wr_cnt32;
    @(negedge clk);
    req_valid32 = 1'b1; req_we32 = 1'b1; req_funct3_32 = 3'b000;
    req_addr32 = 16'd0; req_wdata32 = 32'h77;
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready32, rsp_valid32, rsp_err32, mem_en32, mem_we32} !== 5'b10000 ||
        {rsp_rdata32, mem_addr32, mem_wdata32} !== '0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got ctrl=%b rdata=%h addr=%h wdata=%h, want 10000 and 0",
               {req_ready32, rsp_valid32, rsp_err32, mem_en32, mem_we32},
               rsp_rdata32, mem_addr32, mem_wdata32);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt32 != w0 || ram32[0] !== 32'h1122_3344) begin
      errors++;
      $display("[TB] FAIL midop_nowrite: got writes=%0d word0=%h, want 0 11223344",
               wr_cnt32 - w0, ram32[0]);
    end
    issue(1'b0, 1'b0, 3'b010, 16'd0, 64'h0, lat, rdc, wrc, d, e);
    checks++;
    if (d !== 64'h1122_3344) begin
      errors++;
      $display("[TB] FAIL midop_recover: got %h, want 11223344", d);
    end
  endtask

  task automatic test_wide;
    int lat, rdc, wrc;
    logic [63:0] d;
    logic e;
    preload(1'b1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, 1'b1, 3'b010, 16'd4, 64'h1, lat, rdc, wrc, d, e);
    checks++;
    if (ram64[0] !== 64'h0000_0001_FFFF_FFFF || lat != 4 || rdc != 1 || wrc != 3) begin
      errors++;
      $display("[TB] FAIL sw64_rmw: got %h lat=%0d rd=%0d wr=%0d, want 00000001ffffffff 4 1 3",
               ram64[0], lat, rdc, wrc);
    end
    issue(1'b1, 1'b0, 3'b010, 16'd0, 64'h0, lat, rdc, wrc, d, e);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL lw64_sext: got %h, want ffffffffffffffff", d);
    end
    issue(1'b1, 1'b0, 3'b110, 16'd0, 64'h0, lat, rdc, wrc, d, e);
    checks++;
    if (d !== 64'h0000_0000_FFFF_FFFF || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lwu64: got %h err=%b, want 00000000ffffffff 0", d, e);
    end
    issue(1'b1, 1'b1, 3'b011, 16'd8, 64'h0123_4567_89AB_CDEF, lat, rdc, wrc, d, e);
    checks++;
    if (ram64[1] !== 64'h0123_4567_89AB_CDEF || lat != 2 || rdc != -1) begin
      errors++;
      $display("[TB] FAIL sd64: got %h lat=%0d rd=%0d, want 0123456789abcdef 2 -1",
               ram64[1], lat, rdc);
    end
    issue(1'b1, 1'b0, 3'b001, 16'd14, 64'h0, lat, rdc, wrc, d, e);
    checks++;
    if (d !== 64'h0000_0000_0000_0123) begin
      errors++;
      $display("[TB] FAIL lh64_lane3: got %h, want 0000000000000123", d);
    end
    issue(1'b1, 1'b0, 3'b011, 16'd4, 64'h0, lat, rdc, wrc, d, e);
    checks++;
    if (e !== 1'b1 || lat != 1) begin
      errors++;
      $display("[TB] FAIL ld64_misaligned: got err=%b lat=%0d, want 1 1", e, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid32 = 1'b0; req_we32 = 1'b0; req_funct3_32 = '0; req_addr32 = '0; req_wdata32 = '0;
    req_valid64 = 1'b0; req_we64 = 1'b0; req_funct3_64 = '0; req_addr64 = '0; req_wdata64 = '0;
    rsp_ready32 = 1'b1;
    rsp_ready64 = 1'b1;
    test_reset();
    test_load_extract();
    test_subword_store();
    test_full_store();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
